// File: rtl/hazard_ctrl.sv
//------------------------------------------------------------------------------
// hazard_ctrl: five-stage RV32I hazard, forwarding and memory-wait controller.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic [1:0]       result_src_e,
    input  logic             pc_src_e,
    input  logic             regwrite_m,
    input  logic [4:0]       rd_m,
    input  logic             regwrite_w,
    input  logic [4:0]       rd_w,
    input  logic             dmem_req_m,
    input  logic             dmem_ready,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int WC_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WC_W-1:0]    wait_cnt_q;
    logic               halt_q;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic [CNT_W-1:0]   flush_cnt_q;

    logic               mem_stall;
    logic               lw_stall;

    always_comb begin
        mem_stall = 1'b1;
        case (state_q)
            S_RUN:   mem_stall = dmem_req_m & ~dmem_ready;
            S_WAIT:  mem_stall = ~dmem_ready;
            default: mem_stall = 1'b1;
        endcase
    end

    assign lw_stall = (result_src_e == 2'b01) && (rd_e != 5'd0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));

    // A memory freeze suppresses redirects so they are replayed once it ends.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else begin
            stall_f = lw_stall;
            stall_d = lw_stall;
            flush_d = pc_src_e;
            flush_e = lw_stall | pc_src_e;
        end
    end

    always_comb begin
        forward_a_e = 2'b00;
        if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs1_e))
            forward_a_e = 2'b10;
        else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs1_e))
            forward_a_e = 2'b01;
    end

    always_comb begin
        forward_b_e = 2'b00;
        if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs2_e))
            forward_b_e = 2'b10;
        else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs2_e))
            forward_b_e = 2'b01;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_RUN;
            wait_cnt_q  <= '0;
            halt_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (mem_stall) begin
                        state_q    <= S_WAIT;
                        wait_cnt_q <= WC_W'(1);
                    end
                end
                S_WAIT: begin
                    if (dmem_ready) begin
                        state_q    <= S_RUN;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == WC_W'(MEM_TIMEOUT)) begin
                        state_q <= S_ERR;
                        halt_q  <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WC_W'(1);
                    end
                end
                default: begin
                    state_q <= S_ERR;
                    halt_q  <= 1'b1;
                end
            endcase

            if (stall_f && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_d && (flush_cnt_q != {CNT_W{1'b1}}))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign halt         = halt_q;
    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
//------------------------------------------------------------------------------
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_ctrl;

    logic       clk;
    logic       reset_n;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0] result_src_e;
    logic       pc_src_e, regwrite_m, regwrite_w, dmem_req_m, dmem_ready;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w;
    logic [1:0] forward_a_e, forward_b_e;
    logic       halt;
    logic [3:0] stall_cycles, flush_events;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(
        .MEM_TIMEOUT(4),
        .CNT_W      (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .rs1_e       (rs1_e),
        .rs2_e       (rs2_e),
        .rd_e        (rd_e),
        .result_src_e(result_src_e),
        .pc_src_e    (pc_src_e),
        .regwrite_m  (regwrite_m),
        .rd_m        (rd_m),
        .regwrite_w  (regwrite_w),
        .rd_w        (rd_w),
        .dmem_req_m  (dmem_req_m),
        .dmem_ready  (dmem_ready),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .stall_e     (stall_e),
        .stall_m     (stall_m),
        .flush_d     (flush_d),
        .flush_e     (flush_e),
        .flush_w     (flush_w),
        .forward_a_e (forward_a_e),
        .forward_b_e (forward_b_e),
        .halt        (halt),
        .stall_cycles(stall_cycles),
        .flush_events(flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        result_src_e = 2'b00; pc_src_e = 0; regwrite_m = 0; regwrite_w = 0;
        dmem_req_m = 0; dmem_ready = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    // Packs all stall/flush outputs as {stall_f,d,e,m, flush_d,e,w}.
    function automatic logic [6:0] ctl();
        return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};
    endfunction

    task automatic test_reset();
        do_reset();
        total++; if (halt !== 1'b0) begin bad++; $display("FAIL reset_halt got=%b exp=0", halt); end
        total++; if (stall_cycles !== 4'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cycles); end
        total++; if (flush_events !== 4'd0) begin bad++; $display("FAIL reset_flush_cnt got=%0d exp=0", flush_events); end
        total++; if (ctl() !== 7'b0000000) begin bad++; $display("FAIL reset_ctl got=%b exp=0000000", ctl()); end
        total++; if ({forward_a_e, forward_b_e} !== 4'b0000) begin bad++; $display("FAIL reset_fwd got=%b exp=0000", {forward_a_e, forward_b_e}); end
    endtask

    task automatic test_load_use();
        do_reset();
        result_src_e = 2'b01; rd_e = 5'd5; rs2_d = 5'd5; rs1_d = 5'd9;
        #1;
        total++; if (ctl() !== 7'b1100010) begin bad++; $display("FAIL lu_ctl got=%b exp=1100010", ctl()); end
        tick();
        clear_inputs();
        #1;
        total++; if (stall_cycles !== 4'd1) begin bad++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cycles); end
        total++; if (ctl() !== 7'b0000000) begin bad++; $display("FAIL lu_release got=%b exp=0000000", ctl()); end
        result_src_e = 2'b01; rd_e = 5'd0; rs1_d = 5'd0; rs2_d = 5'd0;
        #1;
        total++; if (ctl() !== 7'b0000000) begin bad++; $display("FAIL lu_x0 got=%b exp=0000000", ctl()); end
        result_src_e = 2'b00; rd_e = 5'd6; rs1_d = 5'd6;
        #1;
        total++; if (ctl() !== 7'b0000000) begin bad++; $display("FAIL lu_nonload got=%b exp=0000000", ctl()); end
    endtask

    task automatic test_branch();
        do_reset();
        pc_src_e = 1'b1;
        #1;
        total++; if (ctl() !== 7'b0000110) begin bad++; $display("FAIL br_ctl got=%b exp=0000110", ctl()); end
        tick();
        clear_inputs();
        #1;
        total++; if (flush_events !== 4'd1) begin bad++; $display("FAIL br_flush_cnt got=%0d exp=1", flush_events); end
        total++; if (stall_cycles !== 4'd0) begin bad++; $display("FAIL br_stall_cnt got=%0d exp=0", stall_cycles); end
        // Load-use and branch together: both stall and flush.
        result_src_e = 2'b01; rd_e = 5'd3; rs1_d = 5'd3; pc_src_e = 1'b1;
        #1;
        total++; if (ctl() !== 7'b1100110) begin bad++; $display("FAIL br_lu_ctl got=%b exp=1100110", ctl()); end
        clear_inputs();
    endtask

    task automatic test_forward();
        do_reset();
        regwrite_m = 1; regwrite_w = 1; rd_m = 5'd7; rd_w = 5'd7; rs1_e = 5'd7; rs2_e = 5'd3;
        #1;
        total++; if (forward_a_e !== 2'b10) begin bad++; $display("FAIL fwd_a_mem got=%b exp=10", forward_a_e); end
        total++; if (forward_b_e !== 2'b00) begin bad++; $display("FAIL fwd_b_none got=%b exp=00", forward_b_e); end
        regwrite_m = 0; rs2_e = 5'd7;
        #1;
        total++; if (forward_a_e !== 2'b01) begin bad++; $display("FAIL fwd_a_wb got=%b exp=01", forward_a_e); end
        total++; if (forward_b_e !== 2'b01) begin bad++; $display("FAIL fwd_b_wb got=%b exp=01", forward_b_e); end
        regwrite_m = 1; rd_m = 5'd0; rd_w = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
        #1;
        total++; if ({forward_a_e, forward_b_e} !== 4'b0000) begin bad++; $display("FAIL fwd_x0 got=%b exp=0000", {forward_a_e, forward_b_e}); end
        rd_m = 5'd12; rd_w = 5'd4; rs1_e = 5'd4; rs2_e = 5'd12;
        #1;
        total++; if ({forward_a_e, forward_b_e} !== 4'b0110) begin bad++; $display("FAIL fwd_mix got=%b exp=0110", {forward_a_e, forward_b_e}); end
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        do_reset();
        dmem_req_m = 1; dmem_ready = 0; pc_src_e = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (ctl() !== 7'b1111001) begin bad++; $display("FAIL mw_freeze%0d got=%b exp=1111001", i, ctl()); end
            tick();
        end
        dmem_ready = 1;
        #1;
        total++; if (ctl() !== 7'b0000110) begin bad++; $display("FAIL mw_ready got=%b exp=0000110", ctl()); end
        tick();
        clear_inputs();
        #1;
        total++; if (stall_cycles !== 4'd3) begin bad++; $display("FAIL mw_stall_cnt got=%0d exp=3", stall_cycles); end
        total++; if (flush_events !== 4'd1) begin bad++; $display("FAIL mw_flush_cnt got=%0d exp=1", flush_events); end
        total++; if (ctl() !== 7'b0000000 || halt !== 1'b0) begin bad++; $display("FAIL mw_run got=%b/%b exp=0000000/0", ctl(), halt); end
    endtask

    task automatic test_timeout();
        do_reset();
        dmem_req_m = 1; dmem_ready = 0;
        for (int i = 1; i <= 5; i++) begin
            #1;
            total++; if (halt !== 1'b0) begin bad++; $display("FAIL to_early_halt%0d got=%b exp=0", i, halt); end
            tick();
        end
        total++; if (halt !== 1'b1) begin bad++; $display("FAIL to_halt got=%b exp=1", halt); end
        dmem_req_m = 0; dmem_ready = 1; pc_src_e = 1;
        #1;
        total++; if (ctl() !== 7'b1111001) begin bad++; $display("FAIL to_err_ctl got=%b exp=1111001", ctl()); end
        tick();
        tick();
        total++; if (halt !== 1'b1 || ctl() !== 7'b1111001) begin bad++; $display("FAIL to_err_stay got=%b/%b exp=1/1111001", halt, ctl()); end
        clear_inputs();
        #1;
        reset_n = 1'b0;
        #1;
        total++; if (halt !== 1'b0) begin bad++; $display("FAIL to_rst_halt got=%b exp=0", halt); end
        total++; if ({stall_cycles, flush_events} !== 8'd0) begin bad++; $display("FAIL to_rst_cnt got=%0d/%0d exp=0/0", stall_cycles, flush_events); end
        total++; if (ctl() !== 7'b0000000) begin bad++; $display("FAIL to_rst_ctl got=%b exp=0000000", ctl()); end
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_ready_at_timeout();
        do_reset();
        dmem_req_m = 1; dmem_ready = 0;
        repeat (4) tick();
        dmem_ready = 1;
        #1;
        total++; if (ctl() !== 7'b0000000) begin bad++; $display("FAIL rt_ready_ctl got=%b exp=0000000", ctl()); end
        tick();
        clear_inputs();
        tick();
        total++; if (halt !== 1'b0) begin bad++; $display("FAIL rt_no_halt got=%b exp=0", halt); end
        total++; if (stall_cycles !== 4'd4) begin bad++; $display("FAIL rt_stall_cnt got=%0d exp=4", stall_cycles); end
    endtask

    task automatic test_saturation();
        do_reset();
        result_src_e = 2'b01; rd_e = 5'd8; rs1_d = 5'd8;
        repeat (20) tick();
        total++; if (stall_cycles !== 4'd15) begin bad++; $display("FAIL sat_stall got=%0d exp=15", stall_cycles); end
        clear_inputs();
        pc_src_e = 1;
        repeat (17) tick();
        total++; if (flush_events !== 4'd15) begin bad++; $display("FAIL sat_flush got=%0d exp=15", flush_events); end
        clear_inputs();
    endtask

    initial begin
        reset_n = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch();
        test_forward();
        test_mem_wait();
        test_timeout();
        test_ready_at_timeout();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage RV32I core. It detects load-use and control hazards and generates per-stage stall and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also generates EX-stage forwarding selects and freezes the pipeline while data memory is not ready. A wait-state FSM enforces a memory timeout that halts the core, and saturating counters record stall and flush activity for performance debug.

## Interface
Parameters:
- MEM_TIMEOUT, 16 — maximum WAIT-state cycles before halting (≥1).
- CNT_W, 32 — width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rs1_d, rs2_d  in  5  source registers of the instruction in ID.
- rs1_e, rs2_e, rd_e  in  5  register fields of the instruction in EX.
- result_src_e  in  2  EX result source; 2'b01 means load.
- pc_src_e  in  1  taken branch or jump resolved in EX.
- regwrite_m, rd_m  in  1/5  MEM-stage writeback enable and destination.
- regwrite_w, rd_w  in  1/5  WB-stage writeback enable and destination.
- dmem_req_m  in  1  MEM-stage instruction accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- stall_f, stall_d, stall_e, stall_m  out  1  hold the PC and the IF/ID, ID/EX and EX/MEM registers.
- flush_d, flush_e, flush_w  out  1  bubble the IF/ID, ID/EX and MEM/WB registers.
- forward_a_e, forward_b_e  out  2  ALU operand select: 00 register file, 01 WB result, 10 MEM ALU result.
- halt  out  1  core halted on memory timeout.
- stall_cycles, flush_events  out  CNT_W  saturating performance counters.

## Operation
- FSM states:
  - RUN (reset state).
  - WAIT (memory outstanding).
  - ERR (timeout; terminal until reset).
- mem_stall is `dmem_req_m & ~dmem_ready` in RUN and `~dmem_ready` in WAIT. It is forced to 1 in ERR.
- RUN → WAIT when mem_stall; wait_cnt is set to 1.
- In WAIT:
  - dmem_ready → RUN, wait_cnt ← 0.
  - else if wait_cnt == MEM_TIMEOUT → ERR.
  - else wait_cnt increments.
- In ERR: halt = 1 and all stall outputs are 1. All flush outputs except flush_w are 0, and all other inputs are ignored.
- Priority: mem_stall, then load-use, then control flush.
- When mem_stall = 1:
  - stall_f, stall_d, stall_e and stall_m = 1, flush_w = 1.
  - flush_d and flush_e are forced to 0, so a pending redirect waits until the freeze ends.
- lw_stall = `result_src_e == 01 & rd_e != 0 & (rd_e == rs1_d | rd_e == rs2_d)`.
- When mem_stall = 0:
  - stall_f = stall_d = lw_stall.
  - flush_d = pc_src_e.
  - flush_e = lw_stall | pc_src_e.
  - stall_e = stall_m = flush_w = 0.
- Forwarding, operand A (B is identical using rs2_e):
  - 10 if `regwrite_m & rd_m != 0 & rd_m == rs1_e`.
  - else 01 if `regwrite_w & rd_w != 0 & rd_w == rs1_e`.
  - else 00.
  - MEM takes priority over WB. Register x0 is never forwarded.
- Forwarding is computed from its inputs in every state.
- stall_cycles increments each cycle stall_f = 1. flush_events increments each cycle flush_d = 1. Both saturate at all-ones and do not wrap.
- Reset mid-access: FSM → RUN, wait_cnt → 0, halt → 0, counters → 0 immediately, regardless of dmem_ready.

## Timing
- Stall, flush and forward outputs are combinational from the inputs and current state, valid in the same cycle. There is no added latency.
- halt, FSM state, wait_cnt and counters are registered and update on the rising edge of clk.
- halt asserts on the edge after a WAIT cycle with wait_cnt == MEM_TIMEOUT and dmem_ready = 0. That is MEM_TIMEOUT+1 consecutive not-ready cycles, counting the entry cycle in RUN.
- A dmem_ready pulse in the same cycle wait_cnt == MEM_TIMEOUT completes normally and returns to RUN; no halt.
- Reset values:
  - Registered outputs: halt = 0, stall_cycles = 0, flush_events = 0.
  - Combinational outputs with inputs quiescent: all stalls and flushes 0, forward selects 00.

## Test plan
- Load-use: result_src_e = 01, rd_e = 5, rs2_d = 5 → stall_f = stall_d = flush_e = 1 and flush_d = 0 for one cycle; stall_cycles goes 0 → 1.
- Load-use with rd_e = 0 and rs1_d = 0 → no stall. Taken branch (pc_src_e = 1) → flush_d = flush_e = 1, stall_f = 0, flush_events +1.
- Forwarding: regwrite_m = regwrite_w = 1, rd_m = rd_w = rs1_e = 7 → forward_a_e = 10. With regwrite_m = 0 → 01. With rd_m = rd_w = rs1_e = 0 → 00.
- Memory wait: dmem_req_m = 1, dmem_ready low for 3 cycles then high, with pc_src_e = 1 throughout → all four stalls and flush_w = 1 for 3 cycles with flush_d = 0. The FSM then returns to RUN and flush_d = 1 on the ready cycle.
- Timeout: MEM_TIMEOUT = 4, dmem_ready held low → halt = 1 after the 5th not-ready edge and all stalls stay high. Deassert reset_n mid-ERR → halt = 0 and counters = 0 immediately.
- Saturation: CNT_W = 4, hold lw_stall for 20 cycles → stall_cycles stops at 15.
